// File: rtl/ram_store_unit.sv
// Store unit: turns byte-addressed sub-word stores into byte-enabled writes
// on a word-addressed RAM port, splitting word-crossing stores into two writes.
module ram_store_unit #(
    parameter int XLEN        = 32,
    parameter int WORD_ADDR_W = 9
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [XLEN-1:0]        req_addr,
    input  logic [XLEN-1:0]        req_wdata,
    input  logic [1:0]             req_size,
    output logic [WORD_ADDR_W-1:0] ram_addr,
    output logic [XLEN-1:0]        ram_wdata,
    output logic [3:0]             ram_byteena,
    output logic                   ram_wren,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WRITE_LO = 2'd1,
        S_WRITE_HI = 2'd2,
        S_ERR      = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_ready;
    logic                   r_wren;
    logic [3:0]             r_byteena;
    logic [WORD_ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]        r_wdata;
    logic                   r_done;
    logic                   r_err;
    logic [2:0]             r_hi_be;
    logic [XLEN-1:0]        r_hi_data;
    logic [WORD_ADDR_W-1:0] r_hi_addr;

    logic [3:0]             w_mask;
    logic [1:0]             w_off;
    logic [6:0]             w_wide;
    logic                   w_spill;
    logic [2*XLEN-1:0]      w_shift_data;
    logic [WORD_ADDR_W-1:0] w_word_idx;
    logic                   w_accept;
    logic                   w_unused_addr;

    // Size-to-mask decode; illegal size enables no lanes.
    always_comb begin
        w_mask = 4'b0000;
        case (req_size)
            2'd0:    w_mask = 4'b0001;
            2'd1:    w_mask = 4'b0011;
            2'd2:    w_mask = 4'b1111;
            default: w_mask = 4'b0000;
        endcase
    end

    assign w_off         = req_addr[1:0];
    assign w_wide        = {3'b000, w_mask} << w_off;
    assign w_spill       = |w_wide[6:4];
    // Upper half of the double-width shift is exactly the spill-over data.
    assign w_shift_data  = {{XLEN{1'b0}}, req_wdata} << {w_off, 3'b000};
    assign w_word_idx    = req_addr[WORD_ADDR_W+1:2];
    assign w_accept      = req_valid && r_ready;
    assign w_unused_addr = ^req_addr[XLEN-1:WORD_ADDR_W+2];

    assign req_ready   = r_ready;
    assign ram_addr    = r_addr;
    assign ram_wdata   = r_wdata;
    assign ram_byteena = r_byteena;
    assign ram_wren    = r_wren;
    assign done        = r_done;
    assign err         = r_err;

    // Store FSM with all RAM-side outputs, done and err registered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_wren    <= 1'b0;
            r_byteena <= 4'b0000;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_hi_be   <= 3'b000;
            r_hi_data <= '0;
            r_hi_addr <= '0;
        end else begin
            r_wren    <= 1'b0;
            r_byteena <= 4'b0000;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            if (w_accept) begin
                if (req_size == 2'd3) begin
                    r_state <= S_ERR;
                    r_err   <= 1'b1;
                    r_ready <= 1'b1;
                end else begin
                    r_state   <= S_WRITE_LO;
                    r_wren    <= 1'b1;
                    r_addr    <= w_word_idx;
                    r_byteena <= w_wide[3:0];
                    r_wdata   <= w_shift_data[XLEN-1:0];
                    r_done    <= !w_spill;
                    r_ready   <= !w_spill;
                    r_hi_be   <= w_wide[6:4];
                    r_hi_data <= w_shift_data[2*XLEN-1:XLEN];
                    r_hi_addr <= w_word_idx + {{(WORD_ADDR_W-1){1'b0}}, 1'b1};
                end
            end else if ((r_state == S_WRITE_LO) && (r_hi_be != 3'b000)) begin
                r_state   <= S_WRITE_HI;
                r_wren    <= 1'b1;
                r_addr    <= r_hi_addr;
                r_byteena <= {1'b0, r_hi_be};
                r_wdata   <= r_hi_data;
                r_done    <= 1'b1;
                r_ready   <= 1'b1;
                r_hi_be   <= 3'b000;
            end else begin
                r_state <= S_IDLE;
                r_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_store_unit.sv
// Self-checking bench for ram_store_unit: expected RAM writes are queued when a
// store is driven and compared by a monitor when the unit writes.
module tb_ram_store_unit;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic [8:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_byteena;
    logic        ram_wren;
    logic        done;
    logic        err;

    typedef struct packed {
        logic        is_err;
        logic [8:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    ram_store_unit #(.XLEN(32), .WORD_ADDR_W(9)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_size   (req_size),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_byteena(ram_byteena),
        .ram_wren   (ram_wren),
        .done       (done),
        .err        (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Byte-by-byte reference placement of a store into one or two words.
    task automatic push_expected(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [1:0] size);
        exp_t lo;
        exp_t hi;
        int   nbytes;
        int   p;
        lo = '0;
        hi = '0;
        if (size == 2'd3) begin
            lo.is_err = 1'b1;
            exp_q.push_back(lo);
            return;
        end
        nbytes = (size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4);
        for (int k = 0; k < nbytes; k++) begin
            p = int'(addr[1:0]) + k;
            if (p < 4) begin
                lo.be[p] = 1'b1;
                lo.data[8*p +: 8] = data[8*k +: 8];
            end else begin
                hi.be[p-4] = 1'b1;
                hi.data[8*(p-4) +: 8] = data[8*k +: 8];
            end
        end
        lo.addr = addr[10:2];
        lo.done = (hi.be == 4'b0000);
        exp_q.push_back(lo);
        if (hi.be != 4'b0000) begin
            hi.addr = lo.addr + 9'd1;
            hi.done = 1'b1;
            exp_q.push_back(hi);
        end
    endtask

    // Scoreboard monitor: every write or error pulse consumes one expected event.
    always @(negedge clock) begin
        if (reset_n && (ram_wren || err || done)) begin
            exp_t e;
            logic [31:0] lane_mask;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_output: wren=%b err=%b done=%b addr=%0d, required no activity",
                         ram_wren, err, done, ram_addr);
            end else begin
                n_pass++;
                e = exp_q.pop_front();
                lane_mask = {{8{e.be[3]}}, {8{e.be[2]}}, {8{e.be[1]}}, {8{e.be[0]}}};
                n_checks++;
                if ({err, ram_wren} !== {e.is_err, !e.is_err})
                    $display("FAIL sb_kind: err/wren=%b%b, required %b%b", err, ram_wren, e.is_err, !e.is_err);
                else n_pass++;
                n_checks++;
                if (done !== e.done)
                    $display("FAIL sb_done: done=%b, required %b", done, e.done);
                else n_pass++;
                if (!e.is_err) begin
                    n_checks++;
                    if (ram_addr !== e.addr)
                        $display("FAIL sb_addr: ram_addr=%0d, required %0d", ram_addr, e.addr);
                    else n_pass++;
                    n_checks++;
                    if (ram_byteena !== e.be)
                        $display("FAIL sb_byteena: ram_byteena=%b, required %b", ram_byteena, e.be);
                    else n_pass++;
                    n_checks++;
                    if ((ram_wdata & lane_mask) !== e.data)
                        $display("FAIL sb_wdata: ram_wdata=%h (masked %h), required %h",
                                 ram_wdata, ram_wdata & lane_mask, e.data);
                    else n_pass++;
                end
            end
        end
    end

    // Drive one request for a single accept edge; unit is expected to be ready.
    task automatic send(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        n_checks++;
        if (req_ready !== 1'b1)
            $display("FAIL ready_before_send: req_ready=%b, required 1", req_ready);
        else n_pass++;
        req_valid = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        req_size  = size;
        push_expected(addr, data, size);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h5A5A_5A5A;
        req_size  = 2'd3;
    endtask

    task automatic wait_drain(input string name);
        int cycles;
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 20) begin
            @(posedge clock);
            cycles++;
        end
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL %s_drain: %0d writes outstanding, required 0", name, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_size  = 2'd0;
        #12;
        n_checks++;
        if ({ram_wren, ram_byteena, ram_addr, ram_wdata, done, err} !== 48'd0)
            $display("FAIL reset_outputs: wren=%b be=%b addr=%0d wdata=%h done=%b err=%b, required all 0",
                     ram_wren, ram_byteena, ram_addr, ram_wdata, done, err);
        else n_pass++;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || ram_wren !== 1'b0)
            $display("FAIL reset_release: req_ready=%b wren=%b, required 1 0", req_ready, ram_wren);
        else n_pass++;
    endtask

    task automatic test_aligned_and_bytes();
        send(32'h0000_0010, 32'hDEAD_BEEF, 2'd2);
        n_checks++;
        if (ram_wren !== 1'b1 || done !== 1'b1)
            $display("FAIL aligned_latency: wren=%b done=%b, required 1 1", ram_wren, done);
        else n_pass++;
        wait_drain("aligned");
        send(32'h0000_0013, 32'h0000_00A5, 2'd0);
        wait_drain("byte_lane");
        send(32'h0000_0022, 32'h0000_BEEF, 2'd1);
        send(32'h0000_0101, 32'h0000_0077, 2'd0);
        wait_drain("sub_word");
    endtask

    task automatic test_crossing_half();
        send(32'h0000_0007, 32'h0000_1234, 2'd1);
        n_checks++;
        if (req_ready !== 1'b0)
            $display("FAIL cross_ready_lo: req_ready=%b, required 0", req_ready);
        else n_pass++;
        @(posedge clock);
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || done !== 1'b1)
            $display("FAIL cross_hi_cycle: req_ready=%b done=%b, required 1 1", req_ready, done);
        else n_pass++;
        wait_drain("cross_half");
    endtask

    task automatic test_wrap();
        send(32'h0000_07FE, 32'hCAFE_F00D, 2'd2);
        wait_drain("wrap");
        send(32'h0000_0803, 32'h8877_6655, 2'd2);
        wait_drain("high_addr_ignored");
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4];
        logic [1:0]  sizes [4];
        addrs = '{32'h0000_0040, 32'h0000_0044, 32'h0000_0048, 32'h0000_004C};
        sizes = '{2'd2, 2'd2, 2'd2, 2'd3};
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_addr  = addrs[i];
            req_wdata = 32'h1111_0000 + 32'(i);
            req_size  = sizes[i];
            push_expected(req_addr, req_wdata, req_size);
            @(posedge clock);
            #1;
            n_checks++;
            if (i < 3 && (ram_wren !== 1'b1 || done !== 1'b1 || req_ready !== 1'b1))
                $display("FAIL b2b_write_%0d: wren=%b done=%b ready=%b, required 1 1 1",
                         i, ram_wren, done, req_ready);
            else if (i == 3 && (err !== 1'b1 || ram_wren !== 1'b0))
                $display("FAIL b2b_err: err=%b wren=%b, required 1 0", err, ram_wren);
            else n_pass++;
        end
        req_valid = 1'b0;
        @(posedge clock);
        #1;
        n_checks++;
        if (err !== 1'b0)
            $display("FAIL err_one_cycle: err=%b, required 0", err);
        else n_pass++;
        wait_drain("back_to_back");
    endtask

    task automatic test_reset_mid_split();
        req_valid = 1'b1;
        req_addr  = 32'h0000_000E;
        req_wdata = 32'hA1B2_C3D4;
        req_size  = 2'd2;
        n_checks++;
        if (req_ready !== 1'b1)
            $display("FAIL split_ready_before: req_ready=%b, required 1", req_ready);
        else n_pass++;
        begin
            exp_t lo;
            push_expected(req_addr, req_wdata, req_size);
            lo = exp_q.pop_front();
            exp_q.delete();
            exp_q.push_back(lo);
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (ram_wren !== 1'b0 || req_ready !== 1'b1 || ram_byteena !== 4'b0000 || done !== 1'b0)
            $display("FAIL reset_mid_split: wren=%b ready=%b be=%b done=%b, required 0 1 0000 0",
                     ram_wren, req_ready, ram_byteena, done);
        else n_pass++;
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        n_checks++;
        if (ram_wren !== 1'b0)
            $display("FAIL no_replay_hi: wren=%b, required 0", ram_wren);
        else n_pass++;
        wait_drain("reset_split");
    endtask

    initial begin
        test_reset();
        test_aligned_and_bytes();
        test_crossing_half();
        test_wrap();
        test_back_to_back();
        test_reset_mid_split();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_store_unit.md
Name: ram_store_unit

Overview:
- Write-side counterpart of the instruction/data ROM read port: turns byte-addressed, sub-word CPU stores into byte-enabled writes on a 512-word internal RAM port.
- Sits between the hart's memory stage and the on-chip RAM macro.
- Shifts store data and byte enables into the addressed byte lanes.
- Splits stores that cross a word boundary into two RAM write cycles.

Parameters:
XLEN, 32, data/address width (from isa_types; only 32 supported)
WORD_ADDR_W, 9, RAM word-address width; RAM word index = addr[WORD_ADDR_W+1:2]

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  store request valid
req_ready  output  1  unit can accept a request this cycle
req_addr  input  XLEN  byte address of store
req_wdata  input  XLEN  store data, right-aligned (byte in [7:0], half in [15:0])
req_size  input  2  0=byte, 1=half, 2=word, 3=illegal
ram_addr  output  WORD_ADDR_W  RAM word address
ram_wdata  output  XLEN  lane-shifted write data
ram_byteena  output  4  per-lane byte enable
ram_wren  output  1  RAM write strobe
done  output  1  one-cycle pulse in the cycle of a request's final RAM write
err  output  1  one-cycle pulse when an illegal-size request is accepted

Behaviour:
- Clock and reset: single clock domain; reset_n is asynchronous and active-low.
- Reset values:
  - State = IDLE.
  - ram_wren=0, ram_byteena=0, ram_addr=0, ram_wdata=0, done=0, err=0.
  - req_ready=1 once reset_n is released.
- Handshake:
  - A request is accepted on a rising edge where req_valid && req_ready.
  - All request fields are captured at that edge; later input changes have no effect.
- Mask and lane math:
  - mask = 4'b0001 / 4'b0011 / 4'b1111 for sizes 0/1/2.
  - off = req_addr[1:0]; wide = mask << off (7 bits).
  - lo_be = wide[3:0]; hi_be = wide[6:4]; spill = |hi_be.
- Registered outputs: all RAM-side outputs, done and err are registered. The first write appears in the cycle after acceptance.
- States:
  - IDLE:
    - req_ready=1; ram_wren=0.
    - On accept with size 0..2 -> WRITE_LO.
    - On accept with size 3 -> ERR.
  - WRITE_LO (one cycle):
    - ram_wren=1; ram_addr = word index; ram_byteena = lo_be.
    - ram_wdata = wdata << (8*off), truncated to 32 bits.
    - If spill -> WRITE_HI; done=0; req_ready=0.
    - Otherwise done=1 and req_ready=1: a new request may be accepted this cycle (goes directly to WRITE_LO/ERR next cycle, else IDLE).
  - WRITE_HI (one cycle):
    - ram_wren=1; ram_addr = word index + 1, modulo 2^WORD_ADDR_W (511 wraps to 0).
    - ram_byteena = {1'b0, hi_be}; ram_wdata = wdata >> (8*(4-off)).
    - done=1; req_ready=1; same back-to-back rule as WRITE_LO.
  - ERR (one cycle):
    - err=1; ram_wren=0; done=0; req_ready=1.
    - Accept allowed as in IDLE.
- Throughput and latency:
  - Aligned or non-crossing stores: 1 per cycle sustained; latency 1 cycle from accept to write.
  - Crossing stores: 2 write cycles; req_ready low for one cycle.
- Don't-care bits:
  - Inactive ram_wdata lanes are don't-care; the bench checks only enabled lanes.
  - ram_addr and ram_wdata are don't-care when ram_wren=0.
- Address bits above WORD_ADDR_W+1 are ignored.
- Reset asserted mid-operation (any state):
  - Immediately forces IDLE and all outputs to reset values.
  - A pending WRITE_HI half is dropped, not replayed.

Test Plan:
- Aligned word: addr=0x10, wdata=0xDEADBEEF, size=2 -> next cycle ram_addr=4, byteena=1111, wdata=0xDEADBEEF, wren=1, done=1.
- Byte lanes: addr=0x13, wdata=0x000000A5, size=0 -> ram_addr=4, byteena=1000, wdata[31:24]=0xA5, single cycle.
- Crossing half: addr=0x07, wdata=0x1234, size=1:
  - cycle 1: ram_addr=1, byteena=1000, wdata[31:24]=0x34.
  - cycle 2: ram_addr=2, byteena=0001, wdata[7:0]=0x12, done=1.
  - req_ready low during cycle 1.
- Wrap: addr=0x7FE, wdata=0xCAFEF00D, size=2:
  - first write ram_addr=511, byteena=1100, lanes[31:16]=0xF00D.
  - second write ram_addr=0, byteena=0011, lanes[15:0]=0xCAFE.
- Back-to-back plus illegal: three aligned words on consecutive cycles, then size=3:
  - three consecutive wren/done pulses with no bubbles.
  - then err=1 for one cycle, wren=0.
- Reset mid-split: assert reset_n=0 during WRITE_LO of a crossing word -> wren=0 and req_ready reset immediately; no WRITE_HI after release.
